// File: rtl/zkr_pkg.sv
// zkr_pkg: shared Zkr seed CSR encodings, controller states and seed word packing.
package zkr_pkg;
    localparam int SEED_W = 16;
    localparam int SEED_OPST_LSB = 30;
    localparam int SEED_ENT_LSB = 0;

    typedef enum logic [1:0] {
        OPST_BIST = 2'b00,
        OPST_WAIT = 2'b01,
        OPST_ES16 = 2'b10,
        OPST_DEAD = 2'b11
    } opst_t;

    typedef enum logic [1:0] {
        ST_BIST,
        ST_RUN,
        ST_DEAD
    } state_t;

    function automatic logic [31:0] seed_word(input opst_t opst, input logic [SEED_W-1:0] ent);
        logic [31:0] w;
        w = '0;
        w[SEED_OPST_LSB +: 2] = opst;
        w[SEED_ENT_LSB +: SEED_W] = ent;
        return w;
    endfunction
endpackage

// File: rtl/seed_fifo.sv
// seed_fifo: synchronous FIFO with flush; a pop frees a slot for a same-cycle push when full.
module seed_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_pop, do_push;

    always_comb begin
        empty   = wp == rp;
        full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rp[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/entropy_seed_ctrl.sv
// entropy_seed_ctrl: supervises the TRNG source, pairs bytes into 16-bit seed words and serves the Zkr seed CSR.
module entropy_seed_ctrl
    import zkr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARTUP_SAMPLES = 16,
    parameter int MAX_FAILS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  es_data_i,
    input  logic        es_valid_i,
    input  logic [1:0]  es_error_i,
    output logic        es_enable_o,
    input  logic        seed_rd_i,
    output logic [31:0] seed_o,
    output logic [1:0]  fail_cnt_o
);
    state_t            state;
    logic [15:0]       scnt;
    logic [7:0]        fails;
    logic [7:0]        hi;
    logic              have_hi, err_q;
    logic              err_now, err_ev, pop, take, push, full, empty;
    logic [SEED_W-1:0] head;
    opst_t             opst;

    always_comb begin
        err_now     = |es_error_i;
        err_ev      = (state != ST_DEAD) && err_now && !err_q;
        opst        = state == ST_DEAD ? OPST_DEAD : state == ST_BIST ? OPST_BIST : empty ? OPST_WAIT : OPST_ES16;
        pop         = seed_rd_i && opst == OPST_ES16;
        take        = state == ST_RUN && es_valid_i && (!full || pop);
        push        = take && have_hi && !err_ev;
        es_enable_o = state == ST_BIST || (state == ST_RUN && !full);
        seed_o      = seed_word(opst, opst == OPST_ES16 ? head : '0);
        fail_cnt_o  = fails > 8'd3 ? 2'd3 : fails[1:0];
    end

    // err_q follows the error level so a held error yields a single event across the BIST restart
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BIST;
            scnt    <= '0;
            fails   <= '0;
            hi      <= '0;
            have_hi <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_now;
            if (err_ev) begin
                fails   <= fails + 8'd1;
                scnt    <= '0;
                have_hi <= 1'b0;
                state   <= (fails + 8'd1 == 8'(MAX_FAILS)) ? ST_DEAD : ST_BIST;
            end else if (state == ST_BIST) begin
                if (es_valid_i && !err_now) begin
                    scnt <= scnt + 16'd1;
                    if (scnt + 16'd1 == 16'(STARTUP_SAMPLES)) state <= ST_RUN;
                end
            end else if (take) begin
                have_hi <= !have_hi;
                if (!have_hi) hi <= es_data_i;
            end
        end
    end

    seed_fifo #(.W(SEED_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (err_ev),
        .din   ({hi, es_data_i}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
endmodule
